sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock FIFO, parametrised in width, depth (any DEPTH>=2, not only powers of two) and flag thresholds.
//  Adds almost-full/almost-empty flags, occupancy count, flush, and sticky overflow/underflow error flags.
//  Sits between same-clock producer/consumer pairs.
//  The dual-clock async FIFO is kept for clock crossings.
// PARAMETERS
//  WIDTH      8   data word width in bits (>=1)
//  DEPTH      16  number of entries (>=2, any integer)
//  AFULL_TH   14  o_afull asserted when count >= AFULL_TH (1..DEPTH)
//  AEMPTY_TH  2   o_aempty asserted when count <= AEMPTY_TH (0..DEPTH-1)
// PORTS
//  i_clk        in   1               clock; all logic on posedge
//  i_rst        in   1               asynchronous, active-high reset
//  i_flush      in   1               synchronous flush: drop all contents
//  i_wdata      in   WIDTH           write data
//  i_wen        in   1               write request
//  i_ren        in   1               read request
//  o_rdata      out  WIDTH           read data
//  o_rvalid     out  1               o_rdata holds a popped/head word
//  o_full       out  1               count == DEPTH
//  o_empty      out  1               count == 0
//  o_afull      out  1               count >= AFULL_TH
//  o_aempty     out  1               count <= AEMPTY_TH
//  o_count      out  $clog2(DEPTH+1) current occupancy, 0..DEPTH
//  o_overflow   out  1               sticky: write attempted while full
//  o_underflow  out  1               sticky: read attempted while empty
// BEHAVIOUR
//  - One clock i_clk; reset is asynchronous and active-high (i_rst).
//  - Reset values: wptr=rptr=0, o_count=0, o_empty=1, o_aempty=1, o_full=0, o_afull=0, o_rvalid=0, o_rdata=0, o_overflow=0, o_underflow=0. Memory is not reset.
//  - Write accepted iff i_wen && !o_full; read accepted iff i_ren && !o_empty. Flags are sampled as registered at that edge.
//  - Write while full: dropped, o_overflow<=1. Read while empty: no pop, o_underflow<=1.
//  - A write and a read on the same edge:
//    - Both are accepted when neither is blocked; count is unchanged.
//    - On full, the read pops and the write is rejected (overflow set).
//    - On empty, the write lands and the read is rejected (underflow set).
//  - Pointers run 0..DEPTH-1 and wrap DEPTH-1 -> 0 explicitly; no modulo-2^n assumption.
//  - count_next = count + wacc - racc. All flags and o_count are registered from count_next, so they are valid the edge after the event.
//  - i_flush: pointers and count go to 0 and flags return to their reset values. It overrides a same-cycle write/read, and neither sets an error flag. o_rvalid<=0. Sticky errors are NOT cleared; only i_rst clears them.
//  - Reset mid-operation: all state drops to reset values immediately (async); in-flight read is lost.
//  - Read latency (default mode):
//    - o_rdata updates 1 cycle after an accepted read.
//    - o_rvalid pulses 1 cycle for each accepted read.
//    - o_rdata holds its last value otherwise.
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
//   - o_rdata = head entry and o_rvalid = !o_empty, both combinational from state.
//   - An accepted i_ren pops the head; the next word appears the edge after.
//   - o_rdata is don't-care while o_rvalid=0.
//  SYNC_FIFO_FWFT_EN undefined: registered 1-cycle read latency as above.
// STRUCTURE
//  sync_fifo_pkg:
//   - function ptr_inc(ptr, depth) with explicit wrap
//   - localparam-style helpers for count width
//   - enum fifo_err_e {ERR_NONE, ERR_OVF, ERR_UNF}, used by the bench scoreboard
//  Sub-module sync_fifo_mem: DEPTH x WIDTH array with 1 write port and 1 read port.
//   - Registered read port by default.
//   - Async read port under SYNC_FIFO_FWFT_EN.
//  Top level holds the pointers, count, flags and error logic.
//  Elaboration-time $error on illegal DEPTH/AFULL_TH/AEMPTY_TH.
// TESTING (WIDTH=8, DEPTH=5, AFULL_TH=4, AEMPTY_TH=1)
//  - Reset then idle: o_empty=1, o_aempty=1, o_full=0, o_count=0, all errors 0.
//  - Write 0x11..0x55 (5 writes) -> o_afull after the 4th, o_full after the 5th. Read 5 -> 0x11..0x55 in order, each 1 cycle after i_ren; o_empty=1 at end.
//  - Wrap: write 3, read 3, repeated 4 times with values 0x01..0x0C -> data order preserved across the 4->0 pointer wrap.
//  - Full + i_wen=1,i_ren=1 -> one pop, write dropped, o_count 5->4, o_overflow=1 (sticky).
//  - Empty + i_wen=1,i_ren=1 with data 0xA5:
//    - o_count=1, o_underflow=1.
//    - Next read returns 0xA5.
//  - Flush at count=3 with i_wen=1 -> o_count=0, o_empty=1, error flags unchanged. Async i_rst mid-burst -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared helpers for the single-clock FIFO: pointer increment
//               with explicit wrap, pointer/count width helpers and the error
//               event enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  // Error events a FIFO access can raise.
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2
  } fifo_err_e;

  // Width of a count that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer that addresses 0..depth-1 (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Advance a pointer, wrapping depth-1 back to 0. Depth need not be a
  // power of two, so the wrap is an explicit compare rather than overflow.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                          input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x WIDTH storage with one write port and one read port.
//               Default build: registered read port (data one cycle after
//               rd_en, held otherwise, cleared by rst).
//               SYNC_FIFO_FWFT_EN defined: asynchronous read port; rst and
//               rd_en are not present in that build.
// Ports       : clk      - clock
//               rst      - async active-high reset of the read register
//               rd_en    - registered read enable
//               wr_en    - write enable
//               wr_addr  - write address
//               wr_data  - write data
//               rd_addr  - read address
//               rd_data  - read data
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic             rst,
  input  logic             rd_en,
`endif
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Storage is deliberately not reset.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = mem[rd_addr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with arbitrary DEPTH (>=2), occupancy
//               count, almost-full/almost-empty thresholds, synchronous
//               flush and sticky overflow/underflow error flags.
//               Build option SYNC_FIFO_FWFT_EN: first-word-fall-through read
//               (o_rdata = head, o_rvalid = !o_empty). Default: registered
//               read with one cycle latency and a one-cycle o_rvalid pulse.
// Ports       : i_clk, i_rst (async, active-high), i_flush
//               i_wdata/i_wen  - write side
//               i_ren          - read request
//               o_rdata/o_rvalid - read data and its qualifier
//               o_full/o_empty/o_afull/o_aempty/o_count - occupancy status
//               o_overflow/o_underflow - sticky error flags (cleared by reset)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_flush,
  input  logic [WIDTH-1:0]            i_wdata,
  input  logic                        i_wen,
  input  logic                        i_ren,
  output logic [WIDTH-1:0]            o_rdata,
  output logic                        o_rvalid,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_afull,
  output logic                        o_aempty,
  output logic [cnt_width(DEPTH)-1:0] o_count,
  output logic                        o_overflow,
  output logic                        o_underflow
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  // Elaboration-time parameter legality checks.
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo: AEMPTY_TH must be in 0..DEPTH-1");
  end

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr_nxt;
  logic [PW-1:0]    rptr_nxt;
  logic [CW-1:0]    count_next;
  logic             wacc;
  logic             racc;
  logic [WIDTH-1:0] mem_rdata;

  // Acceptance uses the registered flags; on a full or empty edge this is
  // what makes a simultaneous read/write resolve to exactly one operation.
  assign wacc = i_wen && !o_full;
  assign racc = i_ren && !o_empty;

  assign count_next = o_count + CW'(wacc) - CW'(racc);
  assign wptr_nxt   = PW'(ptr_inc(32'(wptr), 32'(DEPTH)));
  assign rptr_nxt   = PW'(ptr_inc(32'(rptr), 32'(DEPTH)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr        <= '0;
      rptr        <= '0;
      o_count     <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_afull     <= 1'b0;
      o_aempty    <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_flush) begin
      // Flush wins over any same-cycle access and leaves sticky errors alone.
      wptr     <= '0;
      rptr     <= '0;
      o_count  <= '0;
      o_full   <= 1'b0;
      o_empty  <= 1'b1;
      o_afull  <= 1'b0;
      o_aempty <= 1'b1;
    end else begin
      if (wacc) begin
        wptr <= wptr_nxt;
      end
      if (racc) begin
        rptr <= rptr_nxt;
      end
      o_count  <= count_next;
      o_full   <= (count_next == CW'(DEPTH));
      o_empty  <= (count_next == '0);
      o_afull  <= (count_next >= CW'(AFULL_TH));
      o_aempty <= (count_next <= CW'(AEMPTY_TH));
      if (i_wen && o_full) begin
        o_overflow <= 1'b1;
      end
      if (i_ren && o_empty) begin
        o_underflow <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (i_clk),
    .wr_en   (wacc && !i_flush),
    .wr_addr (wptr),
    .wr_data (i_wdata),
    .rd_addr (rptr),
    .rd_data (mem_rdata)
  );

  // Head word is visible whenever the FIFO holds data.
  assign o_rdata  = mem_rdata;
  assign o_rvalid = !o_empty;
`else
  logic rvalid_q;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (i_clk),
    .rst     (i_rst),
    .rd_en   (racc && !i_flush),
    .wr_en   (wacc && !i_flush),
    .wr_addr (wptr),
    .wr_data (i_wdata),
    .rd_addr (rptr),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= racc && !i_flush;
    end
  end

  assign o_rdata  = mem_rdata;
  assign o_rvalid = rvalid_q;
`endif

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Directed self-checking bench for sync_fifo (default
//               registered-read build) with WIDTH=8, DEPTH=5, AFULL_TH=4,
//               AEMPTY_TH=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 5;
  localparam int AFULL_TH  = 4;
  localparam int AEMPTY_TH = 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] wdata;
  logic             wen;
  logic             ren;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             afull;
  logic             aempty;
  logic [2:0]       count;
  logic             overflow;
  logic             underflow;

  int n_asrt = 0;
  int n_fail = 0;

  // Sticky-error reference, stepped by the error events the bench provokes.
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;

  sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_wdata     (wdata),
    .i_wen       (wen),
    .i_ren       (ren),
    .o_rdata     (rdata),
    .o_rvalid    (rvalid),
    .o_full      (full),
    .o_empty     (empty),
    .o_afull     (afull),
    .o_aempty    (aempty),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stat(input string tag, input int c, input logic e,
                          input logic ae, input logic f, input logic af);
    chk({tag, ".count"},  32'(count),  32'(c));
    chk({tag, ".empty"},  32'(empty),  32'(e));
    chk({tag, ".aempty"}, 32'(aempty), 32'(ae));
    chk({tag, ".full"},   32'(full),   32'(f));
    chk({tag, ".afull"},  32'(afull),  32'(af));
  endtask

  task automatic chk_err(input string tag, input fifo_err_e ev);
    if (ev == ERR_OVF) exp_ovf = 1'b1;
    if (ev == ERR_UNF) exp_unf = 1'b1;
    chk({tag, ".ovf"}, 32'(overflow),  32'(exp_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wen   = w;
    ren   = r;
    wdata = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    rst   = 1'b1;
    flush = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    wdata = '0;

    // Reset state
    #12;
    chk_stat("rst", 0, 1, 1, 0, 0);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.rdata",  32'(rdata),  32'd0);
    chk_err("rst", ERR_NONE);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 8'h00);
    chk_stat("idle", 0, 1, 1, 0, 0);
    chk_err("idle", ERR_NONE);

    // Fill 0x11..0x55
    cyc(1'b1, 1'b0, 8'h11); chk_stat("w1", 1, 0, 1, 0, 0);
    cyc(1'b1, 1'b0, 8'h22); chk_stat("w2", 2, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 8'h33); chk_stat("w3", 3, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 8'h44); chk_stat("w4", 4, 0, 0, 0, 1);
    cyc(1'b1, 1'b0, 8'h55); chk_stat("w5", 5, 0, 0, 1, 1);
    chk_err("fill", ERR_NONE);

    // Drain, one cycle read latency
    cyc(1'b0, 1'b1, 8'h00);
    chk("r1.rvalid", 32'(rvalid), 32'd1); chk("r1.rdata", 32'(rdata), 32'h11);
    chk_stat("r1", 4, 0, 0, 0, 1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("r2.rdata", 32'(rdata), 32'h22); chk_stat("r2", 3, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h00);
    chk("r3.rdata", 32'(rdata), 32'h33); chk_stat("r3", 2, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h00);
    chk("r4.rdata", 32'(rdata), 32'h44); chk_stat("r4", 1, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 8'h00);
    chk("r5.rdata", 32'(rdata), 32'h55); chk_stat("r5", 0, 1, 1, 0, 0);
    cyc(1'b0, 1'b0, 8'h00);
    chk("hold.rvalid", 32'(rvalid), 32'd0);
    chk("hold.rdata",  32'(rdata),  32'h55);
    chk_err("drain", ERR_NONE);

    // Wrap: 4 rounds of write 3 / read 3 carrying 0x01..0x0C
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'(rnd * 3 + k + 1));
      for (int k = 0; k < 3; k++) begin
        cyc(1'b0, 1'b1, 8'h00);
        v = 8'(rnd * 3 + k + 1);
        chk("wrap.rdata",  32'(rdata),  32'(v));
        chk("wrap.rvalid", 32'(rvalid), 32'd1);
      end
    end
    chk_stat("wrap.end", 0, 1, 1, 0, 0);

    // Full with simultaneous write+read
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'(8'h60 + k));
    chk_stat("full2", 5, 0, 0, 1, 1);
    cyc(1'b1, 1'b1, 8'hEE);
    chk_stat("fullrw", 4, 0, 0, 0, 1);
    chk("fullrw.rdata", 32'(rdata), 32'h60);
    chk_err("fullrw", ERR_OVF);
    for (int k = 1; k < 5; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      v = 8'(8'h60 + k);
      chk("fulldrain.rdata", 32'(rdata), 32'(v));
    end
    chk_stat("fulldrain", 0, 1, 1, 0, 0);
    chk_err("fulldrain", ERR_NONE);

    // Empty with simultaneous write+read
    cyc(1'b1, 1'b1, 8'hA5);
    chk_stat("emptyrw", 1, 0, 1, 0, 0);
    chk("emptyrw.rvalid", 32'(rvalid), 32'd0);
    chk_err("emptyrw", ERR_UNF);
    cyc(1'b0, 1'b1, 8'h00);
    chk("emptyrw.rdata", 32'(rdata), 32'hA5);
    chk_stat("emptyrw2", 0, 1, 1, 0, 0);

    // Flush at count 3 with a concurrent write
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'(8'h70 + k));
    chk_stat("preflush", 3, 0, 0, 0, 0);
    flush = 1'b1;
    cyc(1'b1, 1'b0, 8'h77);
    flush = 1'b0;
    chk_stat("flush", 0, 1, 1, 0, 0);
    chk("flush.rvalid", 32'(rvalid), 32'd0);
    chk_err("flush", ERR_NONE);
    cyc(1'b1, 1'b0, 8'h88);
    cyc(1'b0, 1'b1, 8'h00);
    chk("postflush.rdata", 32'(rdata), 32'h88);
    chk_stat("postflush", 0, 1, 1, 0, 0);

    // Async reset mid-burst
    cyc(1'b1, 1'b0, 8'h31);
    cyc(1'b1, 1'b0, 8'h32);
    cyc(1'b0, 1'b1, 8'h00);
    chk("burst.rdata", 32'(rdata), 32'h31);
    wen   = 1'b1;
    wdata = 8'h33;
    #2;
    rst = 1'b1;
    #1;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    chk_stat("arst", 0, 1, 1, 0, 0);
    chk("arst.rvalid", 32'(rvalid), 32'd0);
    chk("arst.rdata",  32'(rdata),  32'd0);
    chk_err("arst", ERR_NONE);
    wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    chk_stat("arst.idle", 0, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo
`default_nettype wire
